// File: rtl/apb_cmd_master.sv
// APB requester: queues read/write commands in a small FIFO and issues them as SETUP/ACCESS
// transfers once init_done is high. Define APB_CMD_MASTER_TIMEOUT_EN to build the ACCESS timeout.
module apb_cmd_master #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          init_done,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  output logic          rsp_write,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_timeout,
  output logic          busy,
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  input  logic [DW-1:0] prdata,
  input  logic          pready
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0] count;
  logic          push, pop, tmo_hit;
  state_t        state_q, state_d;

  assign cmd_ready  = (count != CW'(DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign rd_ptr_nxt = rd_ptr + PW'(1);
  assign busy       = (count != '0) || (state_q != IDLE);

  // On ACCESS->SETUP the current head is popped on that same edge, so the next
  // transfer's fields come from the following slot.
  assign head = pop ? mem[rd_ptr_nxt] : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pclk) begin
    if (!preset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr_nxt;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entry validity is carried by count and the pointers.
  always_ff @(posedge pclk) begin
    if (push) mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE:   if (count != '0 && init_done) state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (pready || tmo_hit) begin
          pop = 1'b1;
          // A command pushed on this same edge is not readable yet; it starts from IDLE.
          state_d = (count > CW'(1) && init_done) ? SETUP : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!preset) begin
      state_q   <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q <= state_d;
      psel    <= (state_d != IDLE);
      penable <= (state_d == ACCESS);
      if (state_d == SETUP) begin
        pwrite <= head.write;
        paddr  <= head.addr;
        pwdata <= head.wdata;
      end
      rsp_valid <= pop;
      rsp_write <= pop && pwrite;
      rsp_rdata <= (pop && !pwrite && !tmo_hit) ? prdata : '0;
    end
  end

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;

  // pready has priority: a ready on the limit edge is a normal completion.
  assign tmo_hit = (state_q == ACCESS) && !pready && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pclk) begin
    if (!preset) begin
      tmo_cnt     <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (state_q == SETUP)                   tmo_cnt <= '0;
      else if (state_q == ACCESS && !pready)  tmo_cnt <= tmo_cnt + TW'(1);
      rsp_timeout <= tmo_hit;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: directed steps plus a randomized phase, checked against
// an in-order command/memory model and a memory-backed APB responder.
module tb_apb_cmd_master;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;
  localparam logic [31:0] DEAD_ADDR = 32'hBAD0_0000;

  logic          pclk = 1'b0;
  logic          preset, init_done;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_write, rsp_timeout, busy;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite, pready;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;

  always #5 pclk = ~pclk;

  apb_cmd_master #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .pclk(pclk), .preset(preset), .init_done(init_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tmo;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];
  int          n_total = 0;
  int          n_bad = 0;
  bit          mon_en = 1'b0;
  int          rsp_seen = 0;
  int          run_len = 0;
  int          last_run = 0;
  bit          rand_waits = 1'b0;
  int          fixed_waits = 0;

  // Content of a location nobody has written yet.
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Offer one command and wait (bounded) for acceptance; record what it must produce.
  task automatic push(input logic wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   budget = 300;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    while (cmd_ready !== 1'b1 && budget > 0) begin
      @(negedge pclk);
      budget--;
    end
    check("push_accept", 64'(cmd_ready), 64'(1));
    @(posedge pclk);
    e.wr = wr; e.addr = a; e.wdata = d;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    e.tmo = (a == DEAD_ADDR);
`else
    e.tmo = 1'b0;
`endif
    if (e.tmo || wr) e.rdata = '0;
    else             e.rdata = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    if (wr && !e.tmo) ref_mem[a] = d;
    exp_q.push_back(e);
    @(negedge pclk);
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic wait_access(input string tag);
    int budget = 300;
    while (!(psel === 1'b1 && penable === 1'b1) && budget > 0) begin
      @(negedge pclk);
      budget--;
    end
    check({tag, "_reach_access"}, 64'(penable), 64'(1));
  endtask

  task automatic access_len(output int n);
    n = 0;
    while (psel === 1'b1 && penable === 1'b1 && n < 300) begin
      n++;
      @(negedge pclk);
    end
  endtask

  task automatic wait_idle(input string tag);
    int budget = 2000;
    while (busy !== 1'b0 && budget > 0) begin
      @(negedge pclk);
      budget--;
    end
    check({tag, "_idle"}, 64'(busy), 64'(0));
    @(negedge pclk);
  endtask

  // Memory-backed responder; never answers DEAD_ADDR.
  initial begin : responder
    int acc_n = 0;
    int wait_now = 0;
    pready = 1'b0;
    prdata = '0;
    forever begin
      @(negedge pclk);
      if (psel === 1'b1 && penable === 1'b1) begin
        if (paddr != DEAD_ADDR && acc_n >= wait_now) begin
          pready = 1'b1;
          if (pwrite) begin
            slv_mem[paddr] = pwdata;
            prdata = $urandom;
          end else begin
            prdata = slv_mem.exists(paddr) ? slv_mem[paddr] : dflt(paddr);
          end
        end else begin
          pready = 1'b0;
          prdata = $urandom;
        end
        acc_n++;
      end else begin
        pready   = 1'($urandom_range(0, 1));
        prdata   = $urandom;
        acc_n    = 0;
        wait_now = rand_waits ? int'($urandom_range(0, 3)) : fixed_waits;
      end
    end
  end

  // Response scoreboard, SETUP field check and APB run-length tracking.
  always @(negedge pclk) begin
    if (mon_en) begin
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_write", 64'(rsp_write), 64'(mon_e.wr));
          check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
          check("rsp_timeout", 64'(rsp_timeout), 64'(mon_e.tmo));
          rsp_seen++;
        end
      end
      if (psel === 1'b1 && penable === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("setup_unexpected", 64'(psel), 64'(0));
        end else begin
          check("setup_paddr", 64'(paddr), 64'(exp_q[0].addr));
          check("setup_pwrite", 64'(pwrite), 64'(exp_q[0].wr));
          if (exp_q[0].wr) check("setup_pwdata", 64'(pwdata), 64'(exp_q[0].wdata));
        end
      end
    end
    if (psel === 1'b1) begin
      run_len++;
    end else if (run_len != 0) begin
      last_run = run_len;
      run_len  = 0;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    int rs0;
    preset = 1'b0; init_done = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0;
    ref_mem[32'h20] = 32'h1234_5678;
    slv_mem[32'h20] = 32'h1234_5678;

    // Reset state
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("rst_psel", 64'(psel), 64'(0));
    check("rst_penable", 64'(penable), 64'(0));
    check("rst_pwrite", 64'(pwrite), 64'(0));
    check("rst_paddr", 64'(paddr), 64'(0));
    check("rst_pwdata", 64'(pwdata), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_write", 64'(rsp_write), 64'(0));
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    check("rst_rsp_timeout", 64'(rsp_timeout), 64'(0));
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    preset = 1'b1;
    mon_en = 1'b1;

    // Write held off by init_done, then SETUP/ACCESS/response timing
    push(1'b1, 32'h10, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      check("hold_no_psel", 64'(psel), 64'(0));
      check("hold_busy", 64'(busy), 64'(1));
      @(negedge pclk);
    end
    init_done = 1'b1;
    @(negedge pclk);
    check("wr_setup_psel", 64'(psel), 64'(1));
    check("wr_setup_penable", 64'(penable), 64'(0));
    check("wr_setup_paddr", 64'(paddr), 64'(32'h10));
    check("wr_setup_pwdata", 64'(pwdata), 64'(32'hDEAD_BEEF));
    check("wr_setup_pwrite", 64'(pwrite), 64'(1));
    @(negedge pclk);
    check("wr_access_psel", 64'(psel), 64'(1));
    check("wr_access_penable", 64'(penable), 64'(1));
    check("wr_access_paddr", 64'(paddr), 64'(32'h10));
    @(negedge pclk);
    check("wr_rsp_valid", 64'(rsp_valid), 64'(1));
    check("wr_rsp_write", 64'(rsp_write), 64'(1));
    check("wr_back_idle", 64'(psel), 64'(0));
    @(negedge pclk);
    check("wr_rsp_pulse", 64'(rsp_valid), 64'(0));

    // Read with three wait states
    fixed_waits = 3;
    push(1'b0, 32'h20, 32'h0);
    wait_access("rd");
    access_len(n);
    check("rd_access_cycles", 64'(n), 64'(4));
    check("rd_rsp_valid", 64'(rsp_valid), 64'(1));
    check("rd_rsp_rdata", 64'(rsp_rdata), 64'(32'h1234_5678));
    check("rd_rsp_timeout", 64'(rsp_timeout), 64'(0));
    wait_idle("rd");

    // pready arriving on the 64th ACCESS cycle is an ordinary completion
    fixed_waits = TMO - 1;
    push(1'b0, 32'h48, 32'h0);
    wait_access("lim");
    access_len(n);
    check("lim_access_cycles", 64'(n), 64'(TMO));
    check("lim_rsp_valid", 64'(rsp_valid), 64'(1));
    check("lim_rsp_timeout", 64'(rsp_timeout), 64'(0));
    check("lim_rsp_rdata", 64'(rsp_rdata), 64'(dflt(32'h48)));
    wait_idle("lim");

    // Fill the FIFO, then five zero-wait transfers back to back
    fixed_waits = 0;
    init_done   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom);
      check("fill_cmd_ready", 64'(cmd_ready), 64'(i < 3));
    end
    rs0 = rsp_seen;
    init_done = 1'b1;
    push(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom);
    wait_idle("burst");
    check("burst_apb_cycles", 64'(last_run), 64'(10));
    check("burst_rsp_count", 64'(rsp_seen - rs0), 64'(5));
    check("burst_all_done", 64'(exp_q.size()), 64'(0));

    // Randomized traffic: random wait states, gaps and init_done stalls
    rand_waits = 1'b1;
    rs0 = rsp_seen;
    for (int i = 0; i < 40; i++) begin
      init_done = (exp_q.size() < DEPTH) ? 1'($urandom_range(0, 1)) : 1'b1;
      push(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom);
      idle(int'($urandom_range(0, 2)));
    end
    init_done = 1'b1;
    wait_idle("rand");
    check("rand_rsp_count", 64'(rsp_seen - rs0), 64'(40));
    check("rand_all_done", 64'(exp_q.size()), 64'(0));
    rand_waits  = 1'b0;
    fixed_waits = 0;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    // Stuck responder aborts after TMO ACCESS cycles; the queued write still runs
    push(1'b0, DEAD_ADDR, 32'h0);
    push(1'b1, 32'h44, $urandom);
    wait_access("tmo");
    access_len(n);
    check("tmo_access_cycles", 64'(n), 64'(TMO));
    check("tmo_rsp_valid", 64'(rsp_valid), 64'(1));
    check("tmo_rsp_timeout", 64'(rsp_timeout), 64'(1));
    check("tmo_rsp_rdata", 64'(rsp_rdata), 64'(0));
    check("tmo_next_setup", 64'(psel), 64'(1));
    wait_idle("tmo");
    check("tmo_all_done", 64'(exp_q.size()), 64'(0));
`endif

    // Reset in the middle of a stuck ACCESS with another command queued
    push(1'b0, DEAD_ADDR, 32'h0);
    push(1'b0, 32'h30, 32'h0);
    wait_access("mid");
    idle(2);
    mon_en = 1'b0;
    preset = 1'b0;
    @(negedge pclk);
    check("mid_rst_psel", 64'(psel), 64'(0));
    check("mid_rst_penable", 64'(penable), 64'(0));
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'(1));
    preset = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check("mid_rst_no_rsp", 64'(rsp_valid), 64'(0));
      check("mid_rst_stay_idle", 64'(psel), 64'(0));
    end
    mon_en = 1'b1;

    // Recovery after reset
    rs0 = rsp_seen;
    push(1'b0, 32'h10, 32'h0);
    wait_idle("recover");
    check("recover_rsp_count", 64'(rsp_seen - rs0), 64'(1));
    check("recover_all_done", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
